// File: rtl/segre_mem_responder_if.sv
// Line-refill request/response bundle between the core arbiter (master)
// and the main-memory responder (slave).
interface segre_mem_responder_if #(
  parameter int ADDR_SIZE = 32,
  parameter int LINE_SIZE = 128
);
  logic                 req_valid_i;
  logic                 req_we_i;
  logic                 req_sel_i;
  logic [ADDR_SIZE-1:0] req_addr_i;
  logic [LINE_SIZE-1:0] req_data_i;
  logic                 req_ready_o;
  logic                 rsp_valid_ic_o;
  logic                 rsp_valid_dc_o;
  logic [LINE_SIZE-1:0] rsp_data_o;
  logic                 busy_o;

  modport master (
    output req_valid_i, req_we_i, req_sel_i, req_addr_i, req_data_i,
    input  req_ready_o, rsp_valid_ic_o, rsp_valid_dc_o, rsp_data_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_sel_i, req_addr_i, req_data_i,
    output req_ready_o, rsp_valid_ic_o, rsp_valid_dc_o, rsp_data_o, busy_o
  );
endinterface

// File: rtl/segre_mem_responder.sv
// Main-memory responder: accepts one line read/write at a time, waits a fixed
// latency, then accesses the line array and pulses the requesting cache.
module segre_mem_responder #(
  parameter int ADDR_SIZE = 32,
  parameter int LINE_SIZE = 128,
  parameter int MEM_LINES = 1024,
  parameter int LATENCY   = 5
) (
  input logic                  clk_i,
  input logic                  rsn_i,
  segre_mem_responder_if.slave bus
);
  localparam int OFF   = $clog2(LINE_SIZE / 8);
  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 cap_we_q;
  logic                 cap_sel_q;
  logic [IDX_W-1:0]     cap_idx_q;
  logic [LINE_SIZE-1:0] cap_data_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 rsp_ic_q;
  logic                 rsp_dc_q;
  logic [LINE_SIZE-1:0] rsp_data_q;
  logic [LINE_SIZE-1:0] mem [MEM_LINES];
  logic                 accept;
  logic                 unused_addr;

  assign accept = bus.req_valid_i && ready_q;

  // Offset and aliasing upper address bits intentionally do not select anything.
  assign unused_addr = ^bus.req_addr_i;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cap_we_q   <= 1'b0;
      cap_sel_q  <= 1'b0;
      cap_idx_q  <= '0;
      cap_data_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      rsp_ic_q   <= 1'b0;
      rsp_dc_q   <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      rsp_ic_q <= 1'b0;
      rsp_dc_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            cap_we_q   <= bus.req_we_i;
            cap_sel_q  <= bus.req_sel_i;
            cap_idx_q  <= bus.req_addr_i[OFF +: IDX_W];
            cap_data_q <= bus.req_data_i;
            cnt_q      <= CNT_LOAD;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            if (LATENCY == 1) state_q <= RESP;
            else              state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == CNT_ONE) state_q <= RESP;
          else                  cnt_q   <= cnt_q - CNT_ONE;
        end
        RESP: begin
          // Response pulse and read data become visible together in the next cycle.
          if (!cap_we_q) rsp_data_q <= mem[cap_idx_q];
          rsp_ic_q <= !cap_sel_q;
          rsp_dc_q <= cap_sel_q;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array has no reset so it maps onto block RAM; a reset in WAIT/RESP drops the write.
  always_ff @(posedge clk_i) begin
    if (state_q == RESP && cap_we_q) mem[cap_idx_q] <= cap_data_q;
  end

  assign bus.req_ready_o    = ready_q;
  assign bus.busy_o         = busy_q;
  assign bus.rsp_valid_ic_o = rsp_ic_q;
  assign bus.rsp_valid_dc_o = rsp_dc_q;
  assign bus.rsp_data_o     = rsp_data_q;
endmodule

// File: tb/tb_segre_mem_responder.sv
// Randomized bench for segre_mem_responder: a LATENCY=5 instance against a
// line-level memory model, plus a LATENCY=1 instance for the fast-path timing.
module tb_segre_mem_responder;
  localparam int ADDR_SIZE = 32;
  localparam int LINE_SIZE = 128;
  localparam int MEM_LINES = 1024;
  localparam int LATENCY   = 5;
  localparam int LINES1    = 16;

  logic clk_i = 1'b0;
  logic rsn_i = 1'b1;
  int checks = 0;
  int errors = 0;

  logic [LINE_SIZE-1:0] model_mem [int];
  logic [LINE_SIZE-1:0] last_rd = '0;

  segre_mem_responder_if #(.ADDR_SIZE(ADDR_SIZE), .LINE_SIZE(LINE_SIZE)) bus ();
  segre_mem_responder_if #(.ADDR_SIZE(ADDR_SIZE), .LINE_SIZE(LINE_SIZE)) bus1 ();

  segre_mem_responder #(
    .ADDR_SIZE(ADDR_SIZE), .LINE_SIZE(LINE_SIZE), .MEM_LINES(MEM_LINES), .LATENCY(LATENCY)
  ) dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .bus(bus)
  );

  segre_mem_responder #(
    .ADDR_SIZE(ADDR_SIZE), .LINE_SIZE(LINE_SIZE), .MEM_LINES(LINES1), .LATENCY(1)
  ) dut1 (
    .clk_i(clk_i), .rsn_i(rsn_i), .bus(bus1)
  );

  always #5 clk_i = ~clk_i;

  function automatic int line_of(input logic [31:0] addr, input int lines);
    return int'((addr >> 4) % lines);
  endfunction

  function automatic logic [LINE_SIZE-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one request on the LATENCY instance and measures its response.
  // Must be called at a point between edges; returns at the sample of the pulse cycle.
  task automatic run_txn(input logic we, input logic sel, input logic [31:0] addr,
                         input logic [LINE_SIZE-1:0] data, output int wait_cyc,
                         output int lat, output logic got_ic, output logic got_dc,
                         output logic [LINE_SIZE-1:0] rdata);
    wait_cyc = -1;
    lat      = -1;
    got_ic   = 1'b0;
    got_dc   = 1'b0;
    rdata    = '0;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_sel_i   = sel;
    bus.req_addr_i  = addr;
    bus.req_data_i  = data;
    for (int n = 0; n < 64; n++) begin
      if (bus.req_ready_o) begin
        wait_cyc = n;
        break;
      end
      @(negedge clk_i);
    end
    if (wait_cyc < 0) begin
      bus.req_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'($urandom);
    bus.req_sel_i   = ~sel;
    bus.req_addr_i  = $urandom;
    bus.req_data_i  = rand_line();
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk_i);
      if (bus.rsp_valid_ic_o || bus.rsp_valid_dc_o) begin
        lat    = c - 1;
        got_ic = bus.rsp_valid_ic_o;
        got_dc = bus.rsp_valid_dc_o;
        rdata  = bus.rsp_data_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit pulse_seen = 0;
    bus.req_valid_i = 0; bus.req_we_i = 0; bus.req_sel_i = 0; bus.req_addr_i = '0; bus.req_data_i = '0;
    bus1.req_valid_i = 0; bus1.req_we_i = 0; bus1.req_sel_i = 0; bus1.req_addr_i = '0; bus1.req_data_i = '0;
    #2 rsn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({bus.req_ready_o, bus.rsp_valid_ic_o, bus.rsp_valid_dc_o, bus.busy_o} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {bus.req_ready_o, bus.rsp_valid_ic_o, bus.rsp_valid_dc_o, bus.busy_o});
    end
    checks++;
    if (bus.rsp_data_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 0", bus.rsp_data_o);
    end
    rsn_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({bus.req_ready_o, bus.busy_o} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL idle_ready_busy: got %b expected 10", {bus.req_ready_o, bus.busy_o});
    end
    checks++;
    if (bus1.req_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_ready_lat1: got %b expected 1", bus1.req_ready_o);
    end
    for (int c = 0; c < 20; c++) begin
      if (bus.rsp_valid_ic_o || bus.rsp_valid_dc_o) pulse_seen = 1;
      @(negedge clk_i);
    end
    checks++;
    if (pulse_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_pulse: got %b expected 0", pulse_seen);
    end
  endtask

  task automatic test_write_read();
    logic [LINE_SIZE-1:0] line_a = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    int w, lat;
    logic ic, dc;
    logic [LINE_SIZE-1:0] rd;
    run_txn(1'b1, 1'b1, 32'h40, line_a, w, lat, ic, dc, rd);
    checks++;
    if (lat !== LATENCY) begin errors++; $display("[TB] FAIL wr_latency: got %0d expected %0d", lat, LATENCY); end
    checks++;
    if ({ic, dc} !== 2'b01) begin errors++; $display("[TB] FAIL wr_route: got %b expected 01", {ic, dc}); end
    checks++;
    if (rd !== last_rd) begin errors++; $display("[TB] FAIL wr_data_held: got %h expected %h", rd, last_rd); end
    model_mem[line_of(32'h40, MEM_LINES)] = line_a;

    run_txn(1'b0, 1'b0, 32'h4C, rand_line(), w, lat, ic, dc, rd);
    checks++;
    if (w !== 0) begin errors++; $display("[TB] FAIL rd_accept_wait: got %0d expected 0", w); end
    checks++;
    if (lat !== LATENCY) begin errors++; $display("[TB] FAIL rd_latency: got %0d expected %0d", lat, LATENCY); end
    checks++;
    if ({ic, dc} !== 2'b10) begin errors++; $display("[TB] FAIL rd_route: got %b expected 10", {ic, dc}); end
    checks++;
    if (rd !== line_a) begin errors++; $display("[TB] FAIL rd_data: got %h expected %h", rd, line_a); end
    last_rd = line_a;
    @(negedge clk_i);
    checks++;
    if ({bus.rsp_valid_ic_o, bus.rsp_valid_dc_o} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL pulse_width: got %b expected 00", {bus.rsp_valid_ic_o, bus.rsp_valid_dc_o});
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int low_run = 0, bad_low = 0, bad_gap = 0, pulses = 0, bad_data = 0, dc_seen = 0;
    logic [LINE_SIZE-1:0] exp_line = model_mem[line_of(32'h40, MEM_LINES)];
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_sel_i   = 1'b0;
    bus.req_addr_i  = 32'h40;
    bus.req_data_i  = '0;
    for (int c = 0; c < 40; c++) begin
      if (bus.req_ready_o) begin
        if (acc.size() > 0) begin
          if (low_run != LATENCY) bad_low++;
          if (c - acc[acc.size()-1] != LATENCY + 1) bad_gap++;
        end
        acc.push_back(c);
        low_run = 0;
      end else begin
        low_run++;
      end
      if (bus.rsp_valid_ic_o) begin
        pulses++;
        if (bus.rsp_data_o !== exp_line) bad_data++;
      end
      if (bus.rsp_valid_dc_o) dc_seen++;
      @(negedge clk_i);
    end
    bus.req_valid_i = 1'b0;
    checks++;
    if (acc.size() !== 7) begin errors++; $display("[TB] FAIL b2b_accepts: got %0d expected 7", acc.size()); end
    checks++;
    if (bad_gap !== 0) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d bad gaps expected 0", bad_gap); end
    checks++;
    if (bad_low !== 0) begin errors++; $display("[TB] FAIL b2b_ready_low: got %0d bad runs expected 0", bad_low); end
    checks++;
    if (pulses !== 6) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d expected 6", pulses); end
    checks++;
    if ({bad_data, dc_seen} !== {32'd0, 32'd0}) begin
      errors++;
      $display("[TB] FAIL b2b_data_route: got %0d bad data %0d dc pulses expected 0 0", bad_data, dc_seen);
    end
    last_rd = exp_line;
    for (int n = 0; n < 20 && !bus.req_ready_o; n++) @(negedge clk_i);
  endtask

  task automatic test_alias();
    logic [LINE_SIZE-1:0] line_a = rand_line();
    logic [31:0] alias_addr = 32'(MEM_LINES * 16);
    int w, lat;
    logic ic, dc;
    logic [LINE_SIZE-1:0] rd;
    run_txn(1'b1, 1'($urandom), 32'h0, line_a, w, lat, ic, dc, rd);
    model_mem[0] = line_a;
    checks++;
    if (lat !== LATENCY) begin errors++; $display("[TB] FAIL alias_wr_latency: got %0d expected %0d", lat, LATENCY); end
    run_txn(1'b0, 1'b0, alias_addr, rand_line(), w, lat, ic, dc, rd);
    checks++;
    if (rd !== line_a) begin errors++; $display("[TB] FAIL alias_data: got %h expected %h", rd, line_a); end
    last_rd = line_a;
  endtask

  task automatic test_random();
    int w, lat, idx;
    logic ic, dc, we, sel;
    logic [31:0] addr;
    logic [LINE_SIZE-1:0] wdata, rd, exp;
    for (int i = 0; i < 32; i++) begin
      idx  = 16 + ((i < 8) ? i : int'($urandom_range(0, 7)));
      we   = (i < 8) ? 1'b1 : 1'($urandom);
      sel  = 1'($urandom);
      addr = ($urandom & 32'hFFFF_C000) | (32'(idx) << 4) | 32'($urandom_range(0, 15));
      wdata = rand_line();
      exp  = we ? last_rd : model_mem[line_of(addr, MEM_LINES)];
      run_txn(we, sel, addr, wdata, w, lat, ic, dc, rd);
      checks++;
      if (lat !== LATENCY) begin errors++; $display("[TB] FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, LATENCY); end
      checks++;
      if ({ic, dc} !== (sel ? 2'b01 : 2'b10)) begin
        errors++;
        $display("[TB] FAIL rnd_route[%0d]: got %b expected %b", i, {ic, dc}, sel ? 2'b01 : 2'b10);
      end
      checks++;
      if (rd !== exp) begin errors++; $display("[TB] FAIL rnd_data[%0d]: got %h expected %h", i, rd, exp); end
      if (we) model_mem[line_of(addr, MEM_LINES)] = wdata;
      else    last_rd = exp;
    end
  endtask

  task automatic test_reset_mid();
    logic [LINE_SIZE-1:0] line_b = rand_line();
    int w, lat;
    bit pulse_seen = 0;
    logic ic, dc;
    logic [LINE_SIZE-1:0] rd;
    run_txn(1'b1, 1'b1, 32'h80, line_b, w, lat, ic, dc, rd);
    model_mem[line_of(32'h80, MEM_LINES)] = line_b;
    checks++;
    if (bus.req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_ready: got %b expected 1", bus.req_ready_o); end
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_sel_i   = 1'b1;
    bus.req_addr_i  = 32'h80;
    bus.req_data_i  = ~line_b;
    @(posedge clk_i);
    #1 bus.req_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rsn_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({bus.req_ready_o, bus.busy_o, bus.rsp_valid_dc_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL mid_reset_ctrl: got %b expected 000", {bus.req_ready_o, bus.busy_o, bus.rsp_valid_dc_o});
    end
    @(negedge clk_i);
    rsn_i = 1'b1;
    last_rd = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (bus.rsp_valid_ic_o || bus.rsp_valid_dc_o) pulse_seen = 1;
    end
    checks++;
    if (pulse_seen !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_pulse: got %b expected 0", pulse_seen); end
    run_txn(1'b0, 1'b1, 32'h80, rand_line(), w, lat, ic, dc, rd);
    checks++;
    if (rd !== line_b) begin errors++; $display("[TB] FAIL mid_prior_data: got %h expected %h", rd, line_b); end
    last_rd = line_b;
  endtask

  task automatic test_latency1();
    int acc[$];
    int pls[$];
    int bad_gap = 0, bad_pulse = 0;
    bit r;
    logic [LINE_SIZE-1:0] written = '0;
    for (int n = 0; n < 20 && !bus1.req_ready_o; n++) @(negedge clk_i);
    bus1.req_valid_i = 1'b1;
    bus1.req_we_i    = 1'b1;
    bus1.req_sel_i   = 1'b1;
    bus1.req_addr_i  = 32'h30;
    bus1.req_data_i  = rand_line();
    for (int c = 0; c < 20; c++) begin
      r = bus1.req_ready_o;
      if (r) begin
        acc.push_back(c);
        written = bus1.req_data_i;
      end
      if (bus1.rsp_valid_dc_o) pls.push_back(c);
      @(posedge clk_i);
      #1;
      if (r) bus1.req_data_i = rand_line();
      @(negedge clk_i);
    end
    bus1.req_valid_i = 1'b0;
    for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != 2) bad_gap++;
    for (int i = 0; i < pls.size(); i++) if (i >= acc.size() || pls[i] != acc[i] + 2) bad_pulse++;
    checks++;
    if (acc.size() !== 10) begin errors++; $display("[TB] FAIL lat1_accepts: got %0d expected 10", acc.size()); end
    checks++;
    if (bad_gap !== 0) begin errors++; $display("[TB] FAIL lat1_spacing: got %0d bad gaps expected 0", bad_gap); end
    checks++;
    if ({pls.size(), bad_pulse} !== {32'd9, 32'd0}) begin
      errors++;
      $display("[TB] FAIL lat1_pulses: got %0d pulses %0d misplaced expected 9 0", pls.size(), bad_pulse);
    end
    checks++;
    if ({bus1.req_ready_o, bus1.rsp_valid_dc_o} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL lat1_last_ack: got %b expected 11", {bus1.req_ready_o, bus1.rsp_valid_dc_o});
    end
    bus1.req_valid_i = 1'b1;
    bus1.req_we_i    = 1'b0;
    bus1.req_sel_i   = 1'b0;
    bus1.req_addr_i  = 32'h30 + 32'(LINES1 * 16);
    @(posedge clk_i);
    #1 bus1.req_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({bus1.rsp_valid_ic_o, bus1.rsp_valid_dc_o, bus1.req_ready_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL lat1_resp_cycle: got %b expected 000", {bus1.rsp_valid_ic_o, bus1.rsp_valid_dc_o, bus1.req_ready_o});
    end
    @(negedge clk_i);
    checks++;
    if ({bus1.rsp_valid_ic_o, bus1.rsp_valid_dc_o} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL lat1_rd_route: got %b expected 10", {bus1.rsp_valid_ic_o, bus1.rsp_valid_dc_o});
    end
    checks++;
    if (bus1.rsp_data_o !== written) begin
      errors++;
      $display("[TB] FAIL lat1_rd_data: got %h expected %h", bus1.rsp_data_o, written);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_alias();
    test_random();
    test_reset_mid();
    test_latency1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end
endmodule
